// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - program image loader and run controller for the single-cycle core and Mem4K
//
// Purpose: streams a program image into memory port A at BASE_ADDR, appends a
// terminator word, then releases the core (running on the divided clk_core)
// and watches its fetches until a halt instruction, a cycle-limit timeout, or
// stops early on a load overflow.
//
// Ports:
//   clk_base, rst      base clock, synchronous active-high reset
//   ld_valid/ld_data/ld_last/ld_ready   program word stream
//   core_iabus, core_instr   core fetch address and the fetched word
//   mem_en_wr, mem_abus, mem_dbus_w     memory port A control
//   clk_core, core_rst       divided core clock and core reset
//   cyc_cnt, words_loaded    run cycle count and loaded word count
//   halted, timeout, error   terminal status flags
module boot_sequencer #(
  parameter logic [31:0]     BASE_ADDR   = 32'd2048,
  parameter int              MAX_WORDS   = 1024,
  parameter int              CLK_DIV     = 2,
  parameter longint unsigned TIMEOUT_CYC = 512,
  parameter logic [31:0]     HALT_INSTR  = 32'h00008067,
  parameter logic [31:0]     TERM_WORD   = 32'hFFFF0000,
  parameter int              CW          = $clog2(MAX_WORDS) + 1
) (
  input  logic          clk_base,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic [31:0]   core_iabus,
  input  logic [31:0]   core_instr,
  output logic          mem_en_wr,
  output logic [31:0]   mem_abus,
  output logic [31:0]   mem_dbus_w,
  output logic          clk_core,
  output logic          core_rst,
  output logic [31:0]   cyc_cnt,
  output logic [CW-1:0] words_loaded,
  output logic          halted,
  output logic          timeout,
  output logic          error
);

  // Mem4K holds 4K 32-bit words.
  localparam longint unsigned MEM_BYTES = 64'd16384;
  localparam int              HALF      = CLK_DIV / 2;
  localparam int              DW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [32:0]     TO_LIM    = TIMEOUT_CYC[32:0];

  if (TIMEOUT_CYC >= 64'h1_0000_0000) begin : g_chk_timeout
    $error("TIMEOUT_CYC must fit in the 32-bit cycle counter");
  end
  if ((CLK_DIV < 2) || (CLK_DIV % 2 != 0)) begin : g_chk_div
    $error("CLK_DIV must be even and at least 2");
  end
  if ((64'(BASE_ADDR) + 64'(4 * MAX_WORDS)) >= MEM_BYTES) begin : g_chk_mem
    $error("program image plus terminator does not fit in memory");
  end

  typedef enum logic [2:0] {
    S_LOAD,
    S_TERM,
    S_RUN,
    S_HALTED,
    S_TIMEOUT,
    S_ERROR
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   load_addr;
  logic [DW-1:0] div_cnt;
  logic          div_wrap;
  logic          tick;
  logic          ld_fire;
  logic          cyc_en;
  logic [32:0]   cyc_inc;

  // clk_core flips when the half-period counter wraps; a wrap while low is
  // the rising edge the core samples on.
  assign div_wrap = (div_cnt == DW'(HALF - 1));
  assign tick     = div_wrap && !clk_core;
  assign cyc_inc  = {1'b0, cyc_cnt} + 33'd1;

  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    mem_en_wr  = 1'b0;
    mem_abus   = core_iabus;
    mem_dbus_w = 32'd0;
    ld_fire    = 1'b0;
    cyc_en     = 1'b0;
    case (state)
      S_LOAD: begin
        ld_ready   = 1'b1;
        mem_en_wr  = ld_valid;
        mem_abus   = load_addr;
        mem_dbus_w = ld_data;
        ld_fire    = ld_valid;
        if (ld_valid) begin
          if (ld_last) begin
            state_next = S_TERM;
          end else if (words_loaded == CW'(MAX_WORDS - 1)) begin
            // The overflowing word is still written; nothing after it is.
            state_next = S_ERROR;
          end
        end
      end
      S_TERM: begin
        mem_en_wr  = 1'b1;
        mem_abus   = load_addr;
        mem_dbus_w = TERM_WORD;
        state_next = S_RUN;
      end
      S_RUN: begin
        if (tick) begin
          // Halt takes priority over a coincident timeout.
          if (core_instr == HALT_INSTR) begin
            state_next = S_HALTED;
          end else if (cyc_inc > TO_LIM) begin
            state_next = S_TIMEOUT;
          end else begin
            cyc_en = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_base) begin
    if (rst) begin
      state        <= S_LOAD;
      load_addr    <= BASE_ADDR;
      div_cnt      <= '0;
      clk_core     <= 1'b0;
      core_rst     <= 1'b1;
      cyc_cnt      <= 32'd0;
      words_loaded <= '0;
      halted       <= 1'b0;
      timeout      <= 1'b0;
      error        <= 1'b0;
    end else begin
      state <= state_next;
      if (div_wrap) begin
        div_cnt  <= '0;
        clk_core <= ~clk_core;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      if (ld_fire) begin
        load_addr    <= load_addr + 32'd4;
        words_loaded <= words_loaded + CW'(1);
      end
      if (cyc_en) begin
        cyc_cnt <= cyc_inc[31:0];
      end
      // Registered from the next state so these outputs are glitch-free.
      core_rst <= (state_next != S_RUN);
      halted   <= (state_next == S_HALTED);
      timeout  <= (state_next == S_TIMEOUT);
      error    <= (state_next == S_ERROR);
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// tb/tb_boot_sequencer.sv - self-checking bench for boot_sequencer
module tb_boot_sequencer;

  localparam int          TO    = 40;
  localparam int          MAXW  = 4;
  localparam int          CWA   = $clog2(MAXW) + 1;
  localparam int          CWB   = $clog2(1024) + 1;
  localparam logic [31:0] BASE  = 32'd2048;
  localparam logic [31:0] HALT  = 32'h00008067;
  localparam logic [31:0] TERMW = 32'hFFFF0000;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam int          RUN_BUDGET = 4 * (TO + 6) + 16;

  logic           clk_base = 1'b0;
  logic           rst = 1'b1;
  logic           ld_valid = 1'b0;
  logic [31:0]    ld_data = 32'd0;
  logic           ld_last = 1'b0;
  logic [31:0]    core_iabus = 32'd0;
  logic [31:0]    core_instr = 32'd0;

  logic           ld_ready, mem_en_wr, clk_core, core_rst, halted, timeout, error;
  logic [31:0]    mem_abus, mem_dbus_w, cyc_cnt;
  logic [CWA-1:0] words_loaded;

  logic           b_ld_ready, b_mem_en_wr, b_clk_core, b_core_rst, b_halted, b_timeout, b_error;
  logic [31:0]    b_mem_abus, b_mem_dbus_w, b_cyc_cnt;
  logic [CWB-1:0] b_words_loaded;

  int errors = 0;
  int checks = 0;
  logic [31:0] prog [0:7];

  always #5 clk_base = ~clk_base;

  boot_sequencer #(
    .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .CLK_DIV(4), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_base(clk_base), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .core_iabus(core_iabus),
    .core_instr(core_instr), .mem_en_wr(mem_en_wr), .mem_abus(mem_abus),
    .mem_dbus_w(mem_dbus_w), .clk_core(clk_core), .core_rst(core_rst),
    .cyc_cnt(cyc_cnt), .words_loaded(words_loaded), .halted(halted),
    .timeout(timeout), .error(error)
  );

  boot_sequencer #(.CLK_DIV(2)) dut2 (
    .clk_base(clk_base), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(b_ld_ready), .core_iabus(core_iabus),
    .core_instr(core_instr), .mem_en_wr(b_mem_en_wr), .mem_abus(b_mem_abus),
    .mem_dbus_w(b_mem_dbus_w), .clk_core(b_clk_core), .core_rst(b_core_rst),
    .cyc_cnt(b_cyc_cnt), .words_loaded(b_words_loaded), .halted(b_halted),
    .timeout(b_timeout), .error(b_error)
  );

  function automatic logic [31:0] non_halt();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = w ^ 32'd1;
    return w;
  endfunction

  task automatic do_reset();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    rst = 1'b1;
    @(posedge clk_base); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (clk_core !== 1'b0) begin errors++; $display("FAIL reset_clk_core got=%b exp=0", clk_core); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got=%b exp=1", core_rst); end
    checks++; if (cyc_cnt !== 32'd0) begin errors++; $display("FAIL reset_cyc_cnt got=%0d exp=0", cyc_cnt); end
    checks++; if (words_loaded !== '0) begin errors++; $display("FAIL reset_words got=%0d exp=0", words_loaded); end
    checks++; if ({halted, timeout, error} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {halted, timeout, error}); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready); end
    checks++; if (mem_abus !== BASE) begin errors++; $display("FAIL reset_addr got=%0d exp=%0d", mem_abus, BASE); end
    checks++; if (mem_en_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b exp=0", mem_en_wr); end
  endtask

  // After reset release, CLK_DIV=4 rises on the 2nd edge and holds 2 cycles;
  // CLK_DIV=2 toggles on every edge.
  task automatic test_divider();
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_base); #1;
      checks++;
      if (clk_core !== 1'(((k / 2) % 2))) begin
        errors++; $display("FAIL div4_edge%0d got=%b exp=%0d", k, clk_core, (k / 2) % 2);
      end
      checks++;
      if (b_clk_core !== 1'(k % 2)) begin
        errors++; $display("FAIL div2_edge%0d got=%b exp=%0d", k, b_clk_core, k % 2);
      end
    end
  endtask

  // Streams prog[0..n-1]; idle gaps of gap_lo..gap_hi cycles between words.
  task automatic load_words(input int n, input bit use_last, input int gap_lo, input int gap_hi);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (i == 0) ? 0 : int'($urandom_range(gap_hi, gap_lo));
      repeat (gap) begin
        ld_valid = 1'b0;
        #1;
        checks++; if (mem_en_wr !== 1'b0) begin errors++; $display("FAIL load_idle_wr got=%b exp=0", mem_en_wr); end
        @(posedge clk_base); #1;
      end
      ld_valid = 1'b1;
      ld_data  = prog[i];
      ld_last  = use_last && (i == n - 1);
      #1;
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready w%0d got=%b exp=1", i, ld_ready); end
      checks++;
      if ({mem_en_wr, mem_abus, mem_dbus_w} !== {1'b1, BASE + 32'(4 * i), prog[i]}) begin
        errors++;
        $display("FAIL load_write w%0d got=%b/%0d/%h exp=1/%0d/%h", i, mem_en_wr, mem_abus, mem_dbus_w, BASE + 32'(4 * i), prog[i]);
      end
      @(posedge clk_base); #1;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
    end
  endtask

  // Called in the TERM cycle; returns in the first RUN cycle.
  task automatic check_term(input int n);
    #1;
    checks++;
    if ({mem_en_wr, mem_abus, mem_dbus_w} !== {1'b1, BASE + 32'(4 * n), TERMW}) begin
      errors++;
      $display("FAIL term_write got=%b/%0d/%h exp=1/%0d/%h", mem_en_wr, mem_abus, mem_dbus_w, BASE + 32'(4 * n), TERMW);
    end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL term_ready got=%b exp=0", ld_ready); end
    checks++; if (words_loaded !== CWA'(n)) begin errors++; $display("FAIL term_words got=%0d exp=%0d", words_loaded, n); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL term_core_rst got=%b exp=1", core_rst); end
    @(posedge clk_base); #1;
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL run_core_rst got=%b exp=0", core_rst); end
  endtask

  // Presents HALT from core tick halt_at onwards and checks the run outcome.
  task automatic run_and_check(input int halt_at);
    int ticks;
    bit ended;
    logic prev;
    bit exp_halt;
    int exp_cyc;
    int exp_ticks;
    ticks = 0;
    ended = 1'b0;
    for (int c = 0; c < RUN_BUDGET; c++) begin
      if (core_rst !== 1'b0) begin ended = 1'b1; break; end
      core_iabus = $urandom;
      core_instr = (ticks + 1 >= halt_at) ? HALT : non_halt();
      #1;
      checks++;
      if ({mem_en_wr, mem_abus, mem_dbus_w} !== {1'b0, core_iabus, 32'd0}) begin
        errors++;
        $display("FAIL run_port got=%b/%h/%h exp=0/%h/0", mem_en_wr, mem_abus, mem_dbus_w, core_iabus);
      end
      prev = clk_core;
      @(posedge clk_base); #1;
      if (!prev && clk_core) ticks++;
    end
    checks++;
    if (!ended) begin errors++; $display("FAIL run_bound halt_at=%0d ended=0 exp=1", halt_at); end
    exp_halt  = (halt_at - 1 <= TO);
    exp_cyc   = exp_halt ? halt_at - 1 : TO;
    exp_ticks = exp_halt ? halt_at : TO + 1;
    checks++; if (halted !== exp_halt) begin errors++; $display("FAIL run_halted h%0d got=%b exp=%b", halt_at, halted, exp_halt); end
    checks++; if (timeout !== !exp_halt) begin errors++; $display("FAIL run_timeout h%0d got=%b exp=%b", halt_at, timeout, !exp_halt); end
    checks++; if (cyc_cnt !== 32'(exp_cyc)) begin errors++; $display("FAIL run_cyc h%0d got=%0d exp=%0d", halt_at, cyc_cnt, exp_cyc); end
    checks++; if (ticks != exp_ticks) begin errors++; $display("FAIL run_ticks h%0d got=%0d exp=%0d", halt_at, ticks, exp_ticks); end
    checks++; if ({error, mem_en_wr} !== 2'b00) begin errors++; $display("FAIL run_end_err_wr got=%b exp=00", {error, mem_en_wr}); end
    repeat (9) begin
      core_instr = NOP;
      @(posedge clk_base); #1;
    end
    checks++;
    if ({core_rst, halted, timeout, cyc_cnt} !== {1'b1, exp_halt, !exp_halt, 32'(exp_cyc)}) begin
      errors++;
      $display("FAIL run_frozen got=%b%b%b/%0d exp=1%b%b/%0d", core_rst, halted, timeout, cyc_cnt, exp_halt, !exp_halt, exp_cyc);
    end
  endtask

  task automatic test_directed_load_halt();
    do_reset();
    prog[0] = 32'h00100093;
    prog[1] = 32'h00200113;
    prog[2] = 32'h00008067;
    load_words(3, 1'b1, 1, 1);
    check_term(3);
    run_and_check(5);
  endtask

  task automatic test_timeout_boundary();
    int ha [2] = '{TO + 1, TO + 2};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      prog[0] = non_halt();
      load_words(1, 1'b1, 0, 0);
      check_term(1);
      run_and_check(ha[i]);
    end
  endtask

  task automatic test_random_runs();
    for (int it = 0; it < 6; it++) begin
      int n;
      n = int'($urandom_range(MAXW, 1));
      for (int i = 0; i < n; i++) prog[i] = $urandom;
      do_reset();
      load_words(n, 1'b1, 0, 2);
      check_term(n);
      run_and_check(int'($urandom_range(TO + 4, 1)));
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) prog[i] = non_halt();
    load_words(MAXW, 1'b0, 0, 0);
    ld_valid = 1'b1;
    ld_data  = prog[4];
    #1;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error got=%b exp=1", error); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got=%b exp=0", ld_ready); end
    checks++; if (mem_en_wr !== 1'b0) begin errors++; $display("FAIL ovf_fifth_wr got=%b exp=0", mem_en_wr); end
    checks++; if (words_loaded !== CWA'(MAXW)) begin errors++; $display("FAIL ovf_words got=%0d exp=%0d", words_loaded, MAXW); end
    repeat (6) begin
      @(posedge clk_base); #1;
      checks++;
      if ({core_rst, mem_en_wr, error, words_loaded} !== {1'b1, 1'b0, 1'b1, CWA'(MAXW)}) begin
        errors++;
        $display("FAIL ovf_hold got=%b%b%b/%0d exp=101/%0d", core_rst, mem_en_wr, error, words_loaded, MAXW);
      end
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit found;
    found = 1'b0;
    do_reset();
    prog[0] = NOP;
    load_words(1, 1'b1, 0, 0);
    check_term(1);
    core_instr = NOP;
    for (int c = 0; c < RUN_BUDGET; c++) begin
      if (cyc_cnt === 32'd37) begin found = 1'b1; break; end
      @(posedge clk_base); #1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midrun_reach37 got=%0d exp=37", cyc_cnt); end
    rst = 1'b1;
    @(posedge clk_base); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({cyc_cnt, words_loaded, core_rst, ld_ready, mem_abus} !== {32'd0, CWA'(0), 1'b1, 1'b1, BASE}) begin
      errors++;
      $display("FAIL midrun_reset got=%0d/%0d/%b/%b/%0d exp=0/0/1/1/%0d", cyc_cnt, words_loaded, core_rst, ld_ready, mem_abus, BASE);
    end
    checks++; if ({halted, timeout, error, clk_core} !== 4'b0000) begin errors++; $display("FAIL midrun_flags got=%b exp=0000", {halted, timeout, error, clk_core}); end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_directed_load_halt();
    test_timeout_boundary();
    test_random_runs();
    test_overflow();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
Synthesizable boot/run controller for the single-cycle core and the dual-port Mem4K. While loading, it accepts a program image as a valid/ready word stream and writes it through memory port A at a parametrised base address, followed by a terminator word. It then divides clk_base into clk_core, releases core reset, hands port A to the core's instruction fetch, and ends the run on a halt instruction, a cycle-count timeout or a load overflow.

Parameters:
BASE_ADDR, 32'd2048, byte address of the first program word
MAX_WORDS, 1024, maximum program words accepted (excluding terminator)
CLK_DIV, 2, clk_base cycles per clk_core period; even, >=2
TIMEOUT_CYC, 512, core cycle limit; exceeding it ends the run
HALT_INSTR, 32'h00008067, instruction word that ends the run
TERM_WORD, 32'hFFFF0000, word written directly after the last program word
CW, $clog2(MAX_WORDS)+1, width of the word counter (derived)

Ports:
clk_base  in  1  base clock
rst  in  1  reset: synchronous, active-high; clock clk_base
ld_valid  in  1  load word valid
ld_data  in  32  load word
ld_last  in  1  marks the final program word
ld_ready  out  1  load word accepted when ld_valid & ld_ready
core_iabus  in  32  core instruction address
core_instr  in  32  port A read data (the instruction the core is fetching)
mem_en_wr  out  1  port A write enable (1 = write, 0 = read)
mem_abus  out  32  port A address
mem_dbus_w  out  32  port A write data
clk_core  out  1  divided core clock
core_rst  out  1  core reset
cyc_cnt  out  32  core cycles counted in RUN
words_loaded  out  CW  program words written
halted  out  1  run ended on HALT_INSTR
timeout  out  1  run ended on cycle limit
error  out  1  load overflow

Behaviour:
- States: LOAD, TERM, RUN, HALTED, TIMEOUT, ERROR. The reset state is LOAD.
- Reset values: clk_core=0, divider=0, core_rst=1, cyc_cnt=0, words_loaded=0, halted/timeout/error=0, load address=BASE_ADDR.
- rst asserted in any state, including mid-RUN, restores all reset values on the next clk_base edge.
- Divider:
  - Runs continuously from reset.
  - clk_core toggles every CLK_DIV/2 clk_base cycles, giving 50% duty.
  - A "core tick" is the clk_base cycle on which clk_core toggles 0->1.
- LOAD:
  - ld_ready=1.
  - Combinational outputs: mem_en_wr=ld_valid, mem_abus=load address, mem_dbus_w=ld_data. Memory captures the write on the clk_base edge.
  - On handshake: load address += 4 and words_loaded += 1.
  - Handshake with ld_last: go to TERM.
  - Handshake without ld_last when words_loaded==MAX_WORDS-1: go to ERROR. The overflowing word itself is written.
- TERM:
  - Lasts exactly one cycle; ld_ready=0.
  - mem_en_wr=1, mem_abus=load address, mem_dbus_w=TERM_WORD.
  - Next state RUN.
- RUN:
  - core_rst=0 from the first RUN cycle.
  - mem_en_wr=0, mem_abus=core_iabus, mem_dbus_w=0.
  - On each core tick, evaluated in priority order:
    1. core_instr==HALT_INSTR: go to HALTED, cyc_cnt not incremented.
    2. Else cyc_cnt+1 > TIMEOUT_CYC: go to TIMEOUT.
    3. Else cyc_cnt += 1.
  - If halt and timeout coincide on the same tick, halt wins.
- HALTED / TIMEOUT / ERROR:
  - Terminal; left only by rst.
  - core_rst=1, mem_en_wr=0, ld_ready=0, cyc_cnt and words_loaded frozen.
  - The matching status flag is registered 1 from the first cycle in the state.
  - The divider keeps running.
- Counter widths: cyc_cnt cannot wrap, because TIMEOUT_CYC < 2^32 is enforced by elaboration check. Also checked at elaboration: CLK_DIV even and >=2, and BASE_ADDR+4*MAX_WORDS within the memory size.

Test Plan:
- Directed load: 3 words (0x00100093, 0x00200113, 0x00008067), one idle gap between each, ld_last on word 3 -> writes at 2048/2052/2056; TERM_WORD written at 2060 in the next cycle; words_loaded=3; core_rst falls the cycle after TERM.
- Halt: after load, hold core_instr=0x00008067 from the 5th core tick -> halted=1 the next clk_base cycle; cyc_cnt=4; core_rst=1; timeout=0; mem_en_wr=0.
- Timeout: TIMEOUT_CYC=8, core_instr=0x00000013 forever -> timeout=1 on the 9th core tick, cyc_cnt=8, halted=0; HALT_INSTR presented on that same tick instead gives halted=1, timeout=0.
- Overflow: MAX_WORDS=4, 5 valid words, no ld_last -> 4 writes (2048..2060), error=1, ld_ready=0 afterwards, 5th word not accepted, no TERM write, core_rst stays 1.
- Divider: CLK_DIV=4 -> clk_core period 4 clk_base cycles, high 2 / low 2, first rise 2 cycles after reset release; CLK_DIV=2 -> toggles every cycle.
- Reset mid-RUN: assert rst for 1 cycle at cyc_cnt=37 -> next edge state LOAD, cyc_cnt=0, words_loaded=0, core_rst=1, ld_ready=1, load address 2048.
